ysyx_22050710_isram: RTL and testbench

YSYX_22050710_ISRAM -- requirements
Module: ysyx_22050710_isram

---
 rtl/ysyx_22050710_isram.sv | 107 ++++++++++
 tb/tb_ysyx_22050710_isram.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050710_isram.sv
// Instruction SRAM responder: single-outstanding fetch with fixed LATENCY,
// out-of-range error flag, and a backdoor preload write port.
module ysyx_22050710_isram #(
   parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
   parameter int          DEPTH     = 512,
   parameter int          LATENCY   = 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_inst_sram_en,
   input  logic [31:0]              i_inst_sram_addr,
   output logic [63:0]              o_inst_sram_rdata,
   output logic                     o_inst_sram_ready,
   output logic                     o_inst_sram_rvalid,
   output logic                     o_inst_sram_err,
   input  logic                     i_load_we,
   input  logic [$clog2(DEPTH)-1:0] i_load_idx,
   input  logic [63:0]              i_load_wdata
);

   localparam int IW = $clog2(DEPTH);
   localparam logic [1:0] CNT_INIT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state;
   logic [1:0]  cnt;
   logic [63:0] rbuf;
   logic        rbuf_err;

   logic [63:0] mem [0:DEPTH-1];
   logic [31:0] off;
   logic        in_range;
   logic [IW-1:0] idx;
   logic [63:0] rd_word;
   logic        load_ok;

   // Wrap-around of the subtraction is caught by the explicit addr>=base test.
   assign off      = i_inst_sram_addr - ADDR_BASE;
   assign in_range = (i_inst_sram_addr >= ADDR_BASE) && ((off >> 3) < 32'(DEPTH));
   assign idx      = off[IW+2:3];
   assign rd_word  = in_range ? mem[idx] : 64'h0;

   generate
      if ((2 ** IW) == DEPTH) begin : g_full
         assign load_ok = 1'b1;
      end else begin : g_part
         assign load_ok = (32'(i_load_idx) < 32'(DEPTH));
      end
   endgenerate

   // Storage is intentionally not reset; the read port above samples the
   // pre-edge contents, so a same-edge load cannot leak into the response.
   always_ff @(posedge i_clk) begin
      if (i_load_we && load_ok) mem[i_load_idx] <= i_load_wdata;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state              <= IDLE;
         cnt                <= 2'd0;
         rbuf               <= 64'h0;
         rbuf_err           <= 1'b0;
         o_inst_sram_rdata  <= 64'h0;
         o_inst_sram_rvalid <= 1'b0;
         o_inst_sram_err    <= 1'b0;
         o_inst_sram_ready  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (i_inst_sram_en) begin
                  rbuf              <= rd_word;
                  rbuf_err          <= !in_range;
                  o_inst_sram_ready <= 1'b0;
                  if (LATENCY == 1) begin
                     state              <= RESP;
                     o_inst_sram_rdata  <= rd_word;
                     o_inst_sram_err    <= !in_range;
                     o_inst_sram_rvalid <= 1'b1;
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               if (cnt == 2'd0) begin
                  state              <= RESP;
                  o_inst_sram_rdata  <= rbuf;
                  o_inst_sram_err    <= rbuf_err;
                  o_inst_sram_rvalid <= 1'b1;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            RESP: begin
               state              <= IDLE;
               o_inst_sram_rvalid <= 1'b0;
               o_inst_sram_err    <= 1'b0;
               o_inst_sram_ready  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22050710_isram.sv
// Directed bench: one responder per LATENCY (1..4), inputs driven and
// outputs sampled on the falling clock edge.
module tb_ysyx_22050710_isram;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]        rst;
   logic [3:0]        en;
   logic [3:0][31:0]  addr;
   logic [3:0][63:0]  rdata;
   logic [3:0]        ready;
   logic [3:0]        rvalid;
   logic [3:0]        err;
   logic [3:0]        lwe;
   logic [3:0][8:0]   lidx;
   logic [3:0][63:0]  lwd;

   int n_chk  = 0;
   int n_fail = 0;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      ysyx_22050710_isram #(.LATENCY(g + 1)) dut (
         .i_clk             (clk),
         .i_rst             (rst[g]),
         .i_inst_sram_en    (en[g]),
         .i_inst_sram_addr  (addr[g]),
         .o_inst_sram_rdata (rdata[g]),
         .o_inst_sram_ready (ready[g]),
         .o_inst_sram_rvalid(rvalid[g]),
         .o_inst_sram_err   (err[g]),
         .i_load_we         (lwe[g]),
         .i_load_idx        (lidx[g]),
         .i_load_wdata      (lwd[g])
      );
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic load(input int d, input logic [8:0] idx, input logic [63:0] v);
      @(negedge clk);
      lwe[d] = 1'b1; lidx[d] = idx; lwd[d] = v;
      @(negedge clk);
      lwe[d] = 1'b0;
   endtask

   // Count falling edges until rvalid, bounded; returns 99 on timeout.
   task automatic wait_resp(input int d, output int n);
      bit seen;
      seen = 1'b0;
      n = 0;
      for (int i = 0; i < 12 && !seen; i++) begin
         @(negedge clk);
         n++;
         if (rvalid[d]) seen = 1'b1;
      end
      if (!seen) n = 99;
   endtask

   task automatic fetch(input int d, input logic [31:0] a, output int n);
      en[d] = 1'b1; addr[d] = a;
      @(negedge clk);
      en[d] = 1'b0;
      n = 1;
      if (!rvalid[d]) begin
         wait_resp(d, n);
         if (n != 99) n = n + 1;
      end
   endtask

   initial begin
      int n;
      bit bad;
      rst = '0; en = '0; addr = '0; lwe = '0; lidx = '0; lwd = '0;
      repeat (2) @(negedge clk);
      check("rst_rdata",  64'(rdata[0]), 64'h0);
      check("rst_rvalid", 64'(rvalid[0]), 64'h0);
      check("rst_err",    64'(err[0]), 64'h0);
      check("rst_ready",  64'(ready[0]), 64'h1);
      check("rst_ready3", 64'(ready[3]), 64'h1);
      rst = 4'hF;
      @(negedge clk);

      // LATENCY=1 basic fetch
      load(0, 9'd0, 64'h0000_0013_0000_0093);
      en[0] = 1'b1; addr[0] = 32'h8000_0000;
      @(negedge clk);
      en[0] = 1'b0;
      check("l1_rvalid", 64'(rvalid[0]), 64'h1);
      check("l1_rdata",  rdata[0], 64'h0000_0013_0000_0093);
      check("l1_err",    64'(err[0]), 64'h0);
      check("l1_ready0", 64'(ready[0]), 64'h0);
      @(negedge clk);
      check("l1_ready1", 64'(ready[0]), 64'h1);
      check("l1_rv_low", 64'(rvalid[0]), 64'h0);
      check("l1_hold",   rdata[0], 64'h0000_0013_0000_0093);

      // Range boundaries
      load(0, 9'd511, 64'h5555_AAAA_5555_AAAA);
      fetch(0, 32'h8000_0FF8, n);
      check("last_lat",  64'(n), 64'd1);
      check("last_data", rdata[0], 64'h5555_AAAA_5555_AAAA);
      check("last_err",  64'(err[0]), 64'h0);
      @(negedge clk);
      fetch(0, 32'h7FFF_FFF8, n);
      check("below_rv",   64'(rvalid[0]), 64'h1);
      check("below_err",  64'(err[0]), 64'h1);
      check("below_data", rdata[0], 64'h0);
      @(negedge clk);
      check("err_clr", 64'(err[0]), 64'h0);
      fetch(0, 32'h8000_1000, n);
      check("above_err",  64'(err[0]), 64'h1);
      check("above_data", rdata[0], 64'h0);
      @(negedge clk);

      // LATENCY=3 with a second request held through WAIT
      load(2, 9'd5, 64'hDEAD_BEEF_0123_4567);
      load(2, 9'd6, 64'h6666_6666_6666_6666);
      en[2] = 1'b1; addr[2] = 32'h8000_002C;
      @(negedge clk);
      check("l3_wait_rv",    64'(rvalid[2]), 64'h0);
      check("l3_wait_ready", 64'(ready[2]), 64'h0);
      addr[2] = 32'h8000_0030;
      wait_resp(2, n);
      check("l3_lat",  64'(n + 1), 64'd3);
      check("l3_data", rdata[2], 64'hDEAD_BEEF_0123_4567);
      check("l3_err",  64'(err[2]), 64'h0);
      wait_resp(2, n);
      en[2] = 1'b0;
      check("l3_second_gap",  64'(n), 64'd4);
      check("l3_second_data", rdata[2], 64'h6666_6666_6666_6666);
      @(negedge clk);

      // LATENCY=2 read/write collision on the same word
      load(1, 9'd7, 64'h1111);
      en[1] = 1'b1; addr[1] = 32'h8000_0038;
      lwe[1] = 1'b1; lidx[1] = 9'd7; lwd[1] = 64'h2222;
      @(negedge clk);
      en[1] = 1'b0;
      @(negedge clk);
      lwe[1] = 1'b0;
      check("col_rv",   64'(rvalid[1]), 64'h1);
      check("col_data", rdata[1], 64'h1111);
      @(negedge clk);
      fetch(1, 32'h8000_0038, n);
      check("col_lat",   64'(n), 64'd2);
      check("col_after", rdata[1], 64'h2222);
      @(negedge clk);

      // LATENCY=4, then reset in the middle of WAIT
      load(3, 9'd3, 64'hCAFE_F00D_CAFE_F00D);
      fetch(3, 32'h8000_0018, n);
      check("l4_lat",  64'(n), 64'd4);
      check("l4_data", rdata[3], 64'hCAFE_F00D_CAFE_F00D);
      @(negedge clk);
      en[3] = 1'b1; addr[3] = 32'h8000_0018;
      @(negedge clk);
      en[3] = 1'b0;
      @(negedge clk);
      #2 rst[3] = 1'b0;
      #1;
      check("arst_rdata",  rdata[3], 64'h0);
      check("arst_rvalid", 64'(rvalid[3]), 64'h0);
      check("arst_ready",  64'(ready[3]), 64'h1);
      @(negedge clk);
      rst[3] = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rvalid[3]) bad = 1'b1;
      end
      check("abort_no_rv", 64'(bad), 64'h0);
      fetch(3, 32'h8000_0018, n);
      check("retain_lat",  64'(n), 64'd4);
      check("retain_data", rdata[3], 64'hCAFE_F00D_CAFE_F00D);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
